// File: rtl/mem_stage_seq_pkg.sv
// Shared definitions for the memory stage of the vector pipeline.
//   state_t     : beat sequencer states (IDLE, ACCESS)
//   BEATS_V     : word beats per vector access for the default widths
//   BEAT_CNT_W  : beat counter width for the default widths
//   beat_cnt_w  : beat counter width for an arbitrary V/W pair
package vproc_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int V_DEF      = 128;
  localparam int W_DEF      = 32;
  localparam int BEATS_V    = V_DEF / W_DEF;
  localparam int BEAT_CNT_W = $clog2(BEATS_V) + 1;

  function automatic int beat_cnt_w(input int v, input int w);
    return $clog2(v / w) + 1;
  endfunction

endpackage

// File: rtl/mem_stage_seq_if.sv
// Handshaked W-bit data-memory port.
//   master (memory stage): mem_req, mem_we, mem_addr, mem_wdata out; mem_rdata, mem_ready in
//   slave  (memory)      : the reverse
// mem_rdata is meaningful when mem_req & mem_ready & ~mem_we.
interface mem_stage_seq_if #(
  parameter int W  = 32,
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_stage_seq_beat.sv
// Beat sequencer for scalar/vector memory accesses.
// Splits an access into 1 (scalar) or V/W (vector) word beats on the
// memory port, produces the stall back to the execution-memory register
// and assembles load data across beats.
//   clk, rst    : clock, async active-low reset
//   memop       : a load or store is present in the M stage
//   vect        : vector access (V/W beats) when high
//   is_store    : store when high, load otherwise
//   addr_base   : word address of beat 0
//   store_data  : V-bit store data, beat i takes word i
//   stall       : hold the upstream register
//   ld_data     : load data with the current beat merged in (valid on the last beat)
//   mem         : memory port (master side)
module mem_beat_seq
  import vproc_mem_pkg::*;
#(
  parameter int V  = 128,
  parameter int W  = 32,
  parameter int AW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           memop,
  input  logic           vect,
  input  logic           is_store,
  input  logic [AW-1:0]  addr_base,
  input  logic [V-1:0]   store_data,
  output logic           stall,
  output logic [V-1:0]   ld_data,
  mem_stage_seq_if.master mem
);

  localparam int BEATS  = V / W;
  localparam int BCNT_W = beat_cnt_w(V, W);

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] beat_q, beat_d, last_beat;
  logic [V-1:0]      ldbuf_q;
  logic              req, fire, last;

  always_comb begin
    last_beat = vect ? BCNT_W'(BEATS - 1) : '0;
    last      = (beat_q == last_beat);
    // Gating with rst drops the request and stall as soon as reset asserts,
    // without waiting for the state flops to clear.
    req       = rst & (memop | (state_q == ACCESS));
    fire      = req & mem.mem_ready;
    stall     = rst & memop & ~(mem.mem_ready & last);

    state_d = state_q;
    beat_d  = beat_q;
    if (fire) begin
      if (last) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        state_d = ACCESS;
        beat_d  = beat_q + 1'b1;
      end
    end else if ((state_q == IDLE) && memop) begin
      state_d = ACCESS;
    end

    mem.mem_req   = req;
    mem.mem_we    = req & is_store;
    mem.mem_addr  = addr_base + AW'(beat_q);
    mem.mem_wdata = store_data[int'(beat_q)*W +: W];

    // Last-beat data goes straight to write-back, so merge it here
    // rather than waiting a cycle for ldbuf to capture it.
    ld_data = ldbuf_q;
    ld_data[int'(beat_q)*W +: W] = mem.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Buffer is cleared on completion so the next scalar load sees zeros
  // in the upper words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ldbuf_q <= '0;
    end else if (fire && last) begin
      ldbuf_q <= '0;
    end else if (fire && !is_store) begin
      ldbuf_q[int'(beat_q)*W +: W] <= mem.mem_rdata;
    end
  end

endmodule

// File: rtl/mem_stage_seq_reg.sv
// Generic load-enabled register with asynchronous active-low clear.
//   clk, rst : clock, async active-low reset (q clears to 0)
//   en       : load d when high, hold otherwise
//   d, q     : WIDTH-bit data in / registered out
module gen_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_stage_seq.sv
// Memory stage of the vector pipeline. Classifies the M-stage op, runs
// scalar/vector loads and stores through mem_beat_seq and registers the
// results into the memory-writeback boundary.
//   clk, rst        : clock, async active-low reset
//   regw_M          : register write enable
//   memw_M          : store (wins over regmem_M)
//   regmem_M        : load
//   vect_M          : vector op
//   regScr_M        : destination register
//   ALUrslt_M       : ALU result / store data
//   address_M       : word address (low AW bits used)
//   stall_M         : hold the execution-memory register
//   mem             : data-memory port (master side)
//   *_W             : registered write-back fields, memdata_W = load data
module mem_stage_seq
  import vproc_mem_pkg::*;
#(
  parameter int V  = 128,
  parameter int M  = 4,
  parameter int W  = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regw_M,
  input  logic          memw_M,
  input  logic          regmem_M,
  input  logic          vect_M,
  input  logic [M-1:0]  regScr_M,
  input  logic [V-1:0]  ALUrslt_M,
  input  logic [V-1:0]  address_M,
  output logic          stall_M,
  mem_stage_seq_if.master mem,
  output logic          regw_W,
  output logic          regmem_W,
  output logic          vect_W,
  output logic [M-1:0]  regScr_W,
  output logic [V-1:0]  ALUrslt_W,
  output logic [V-1:0]  memdata_W
);

  logic         memop, is_load, regw_eff;
  logic [V-1:0] ld_data, memdata_d;
  logic         unused_addr_hi;

  assign memop          = memw_M | regmem_M;
  assign is_load        = regmem_M & ~memw_M;
  assign regw_eff       = regw_M & ~(memw_M & regmem_M);
  assign memdata_d      = is_load ? ld_data : '0;
  assign unused_addr_hi = ^address_M[V-1:AW];

  mem_beat_seq #(.V(V), .W(W), .AW(AW)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .memop      (memop),
    .vect       (vect_M),
    .is_store   (memw_M),
    .addr_base  (address_M[AW-1:0]),
    .store_data (ALUrslt_M),
    .stall      (stall_M),
    .ld_data    (ld_data),
    .mem        (mem)
  );

  // ---- M / W boundary: flags bubble while stalled, data fields hold ----
  gen_reg #(.WIDTH(1)) u_regw (
    .clk(clk), .rst(rst), .en(1'b1), .d(~stall_M & regw_eff), .q(regw_W)
  );

  gen_reg #(.WIDTH(1)) u_regmem (
    .clk(clk), .rst(rst), .en(1'b1), .d(~stall_M & is_load), .q(regmem_W)
  );

  gen_reg #(.WIDTH(1)) u_vect (
    .clk(clk), .rst(rst), .en(~stall_M), .d(vect_M), .q(vect_W)
  );

  gen_reg #(.WIDTH(M)) u_regscr (
    .clk(clk), .rst(rst), .en(~stall_M), .d(regScr_M), .q(regScr_W)
  );

  gen_reg #(.WIDTH(V)) u_alurslt (
    .clk(clk), .rst(rst), .en(~stall_M), .d(ALUrslt_M), .q(ALUrslt_W)
  );

  gen_reg #(.WIDTH(V)) u_memdata (
    .clk(clk), .rst(rst), .en(~stall_M), .d(memdata_d), .q(memdata_W)
  );

endmodule

// File: tb/tb_mem_stage_seq.sv
module tb_mem_stage_seq;

  localparam int V  = 128;
  localparam int M  = 4;
  localparam int W  = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          regw_M, memw_M, regmem_M, vect_M;
  logic [M-1:0]  regScr_M;
  logic [V-1:0]  ALUrslt_M, address_M;
  logic          stall_M;
  logic          regw_W, regmem_W, vect_W;
  logic [M-1:0]  regScr_W;
  logic [V-1:0]  ALUrslt_W, memdata_W;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_seq_if #(.W(W), .AW(AW)) mem_bus ();

  mem_stage_seq #(.V(V), .M(M), .W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .regw_M    (regw_M),
    .memw_M    (memw_M),
    .regmem_M  (regmem_M),
    .vect_M    (vect_M),
    .regScr_M  (regScr_M),
    .ALUrslt_M (ALUrslt_M),
    .address_M (address_M),
    .stall_M   (stall_M),
    .mem       (mem_bus),
    .regw_W    (regw_W),
    .regmem_W  (regmem_W),
    .vect_W    (vect_W),
    .regScr_W  (regScr_W),
    .ALUrslt_W (ALUrslt_W),
    .memdata_W (memdata_W)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; registered outputs are
  // sampled at that same point, combinational outputs 1 unit later.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic mw, input logic rm, input logic vc,
                        input logic [M-1:0] rd, input logic [V-1:0] alu,
                        input logic [V-1:0] addr);
    regw_M = rw; memw_M = mw; regmem_M = rm; vect_M = vc;
    regScr_M = rd; ALUrslt_M = alu; address_M = addr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    mem_bus.mem_rdata = '0;
    mem_bus.mem_ready = 1'b0;
    #3;
    n_vec++;
    if ({regw_W, regmem_W, vect_W, regScr_W} !== '0 || ALUrslt_W !== '0 || memdata_W !== '0) begin
      n_err++;
      $display("FAIL reset_w: got regw=%b regmem=%b vect=%b rd=%h alu=%h md=%h required all 0",
               regw_W, regmem_W, vect_W, regScr_W, ALUrslt_W, memdata_W);
    end
    n_vec++;
    if (mem_bus.mem_req !== 1'b0 || stall_M !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got req=%b stall=%b required 0 0", mem_bus.mem_req, stall_M);
    end
    next_edge();
    rst = 1'b1;
    next_edge();
  endtask

  task automatic test_non_mem();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 128'h5, 128'h77);
    mem_bus.mem_ready = 1'b1;  // must be ignored, no request pending
    #1;
    n_vec++;
    if (stall_M !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL nonmem_ctl: got stall=%b req=%b required 0 0", stall_M, mem_bus.mem_req);
    end
    next_edge();
    n_vec++;
    if (regw_W !== 1'b1 || regmem_W !== 1'b0 || regScr_W !== 4'd3 ||
        ALUrslt_W !== 128'h5 || memdata_W !== '0) begin
      n_err++;
      $display("FAIL nonmem_wb: got regw=%b regmem=%b rd=%0d alu=%h md=%h required 1 0 3 5 0",
               regw_W, regmem_W, regScr_W, ALUrslt_W, memdata_W);
    end
  endtask

  task automatic test_scalar_load();
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 128'h10, 128'h10);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'hDEADBEEF;
    #1;
    n_vec++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0 ||
        mem_bus.mem_addr !== 32'h10 || stall_M !== 1'b0) begin
      n_err++;
      $display("FAIL sload_req: got req=%b we=%b addr=%h stall=%b required 1 0 00000010 0",
               mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, stall_M);
    end
    next_edge();
    n_vec++;
    if (memdata_W !== 128'hDEADBEEF || regmem_W !== 1'b1 || regw_W !== 1'b1 || regScr_W !== 4'd5) begin
      n_err++;
      $display("FAIL sload_wb: got md=%h regmem=%b regw=%b rd=%0d required %h 1 1 5",
               memdata_W, regmem_W, regw_W, regScr_W, 128'hDEADBEEF);
    end
  endtask

  task automatic test_vector_load();
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 128'h99, 128'h20);
    mem_bus.mem_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mem_bus.mem_rdata = 32'(32'h11 * (b + 1));
      #1;
      n_vec++;
      if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'(32'h20 + b) ||
          stall_M !== (b < 3)) begin
        n_err++;
        $display("FAIL vload_beat%0d: got req=%b addr=%h stall=%b required 1 %h %b",
                 b, mem_bus.mem_req, mem_bus.mem_addr, stall_M, 32'(32'h20 + b), (b < 3));
      end
      next_edge();
      n_vec++;
      if (regw_W !== (b == 3)) begin
        n_err++;
        $display("FAIL vload_regw%0d: got %b required %b", b, regw_W, (b == 3));
      end
    end
    n_vec++;
    if (memdata_W !== 128'h00000044_00000033_00000022_00000011 || vect_W !== 1'b1 ||
        regScr_W !== 4'd7) begin
      n_err++;
      $display("FAIL vload_data: got md=%h vect=%b rd=%0d required %h 1 7",
               memdata_W, vect_W, regScr_W, 128'h00000044_00000033_00000022_00000011);
    end
  endtask

  task automatic test_vector_store_wait();
    int beat_tab[6]  = '{0, 1, 1, 1, 2, 3};
    logic rdy_tab[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    set_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 128'h0000000D_0000000C_0000000B_0000000A, 128'h40);
    mem_bus.mem_rdata = 32'hFFFF0000;
    for (int c = 0; c < 6; c++) begin
      mem_bus.mem_ready = rdy_tab[c];
      #1;
      n_vec++;
      if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 32'(32'h40 + beat_tab[c]) ||
          mem_bus.mem_wdata !== 32'(32'hA + beat_tab[c]) || stall_M !== (c < 5)) begin
        n_err++;
        $display("FAIL vstore_cyc%0d: got we=%b addr=%h wdata=%h stall=%b required 1 %h %h %b",
                 c, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, stall_M,
                 32'(32'h40 + beat_tab[c]), 32'(32'hA + beat_tab[c]), (c < 5));
      end
      next_edge();
      n_vec++;
      if (regw_W !== 1'b0 || regmem_W !== 1'b0) begin
        n_err++;
        $display("FAIL vstore_wb%0d: got regw=%b regmem=%b required 0 0", c, regw_W, regmem_W);
      end
    end
    n_vec++;
    if (memdata_W !== '0 || ALUrslt_W !== 128'h0000000D_0000000C_0000000B_0000000A) begin
      n_err++;
      $display("FAIL vstore_data: got md=%h alu=%h required 0 %h",
               memdata_W, ALUrslt_W, 128'h0000000D_0000000C_0000000B_0000000A);
    end
  endtask

  task automatic test_reset_mid_access();
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 128'h1, 128'h30);
    mem_bus.mem_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      mem_bus.mem_rdata = 32'hA0A0A0A0 + 32'(b);
      next_edge();
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (mem_bus.mem_req !== 1'b0 || stall_M !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_ctl: got req=%b stall=%b required 0 0", mem_bus.mem_req, stall_M);
    end
    n_vec++;
    if ({regw_W, regmem_W, vect_W, regScr_W} !== '0 || ALUrslt_W !== '0 || memdata_W !== '0) begin
      n_err++;
      $display("FAIL rstmid_w: got regw=%b regmem=%b vect=%b rd=%h alu=%h md=%h required all 0",
               regw_W, regmem_W, vect_W, regScr_W, ALUrslt_W, memdata_W);
    end
    next_edge();
    rst = 1'b1;
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 128'h2, 128'h50);
    mem_bus.mem_rdata = 32'h12345678;
    #1;
    n_vec++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h50 || stall_M !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_req: got req=%b addr=%h stall=%b required 1 00000050 0",
               mem_bus.mem_req, mem_bus.mem_addr, stall_M);
    end
    next_edge();
    n_vec++;
    if (memdata_W !== 128'h12345678 || regmem_W !== 1'b1 || regScr_W !== 4'd4 || vect_W !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_wb: got md=%h regmem=%b rd=%0d vect=%b required %h 1 4 0",
               memdata_W, regmem_W, regScr_W, vect_W, 128'h12345678);
    end
  endtask

  task automatic test_store_priority_wrap();
    logic [31:0] exp_addr;
    set_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 128'h4_00000003_00000002_00000001, 128'hFFFFFFFF);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'h55555555;
    for (int b = 0; b < 4; b++) begin
      exp_addr = 32'hFFFFFFFF + 32'(b);
      #1;
      n_vec++;
      if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== exp_addr) begin
        n_err++;
        $display("FAIL wrap_beat%0d: got we=%b addr=%h required 1 %h",
                 b, mem_bus.mem_we, mem_bus.mem_addr, exp_addr);
      end
      next_edge();
    end
    n_vec++;
    if (regmem_W !== 1'b0 || regw_W !== 1'b0 || memdata_W !== '0 || regScr_W !== 4'd6) begin
      n_err++;
      $display("FAIL wrap_wb: got regmem=%b regw=%b md=%h rd=%0d required 0 0 0 6",
               regmem_W, regw_W, memdata_W, regScr_W);
    end
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 128'hABC, 128'h0);
    mem_bus.mem_ready = 1'b0;
    next_edge();
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 128'hDEF, 128'h0);
    next_edge();
    n_vec++;
    if (regw_W !== 1'b1 || regScr_W !== 4'd2 || ALUrslt_W !== 128'hDEF) begin
      n_err++;
      $display("FAIL b2b_wb: got regw=%b rd=%0d alu=%h required 1 2 def", regw_W, regScr_W, ALUrslt_W);
    end
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_scalar_load();
    test_vector_load();
    test_vector_store_wait();
    test_reset_mid_access();
    test_store_priority_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_seq.md
Name: mem_stage_seq

Overview:
- Memory stage of the vector pipeline; sits directly downstream of the execution-memory pipeline register.
- Consumes the registered M-stage control, destination, ALU result and address, and performs scalar or vector loads/stores over a W-bit handshaked data-memory port.
- A V-bit vector access is sequenced as V/W word beats; stall_M is driven back to the execution-memory register while an access is in flight.
- Results are registered into the memory-writeback boundary (outputs *_W).

Parameters:
- V, 128, vector/ALU result width in bits
- M, 4, register-index width
- W, 32, data-memory word width; V must be an integer multiple of W
- AW, 32, word-address width; taken from address_M[AW-1:0]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- regw_M  in  1  register write enable
- memw_M  in  1  store
- regmem_M  in  1  load (write-back selects memory data)
- vect_M  in  1  vector op
- regScr_M  in  M  destination register
- ALUrslt_M  in  V  ALU result; store data for stores
- address_M  in  V  word address (low AW bits used)
- stall_M  out  1  hold the execution-memory register
- mem_req  out  1  memory request valid
- mem_we  out  1  write when 1, read when 0
- mem_addr  out  AW  word address of current beat
- mem_wdata  out  W  store data of current beat
- mem_rdata  in  W  read data, valid when mem_req & mem_ready & ~mem_we
- mem_ready  in  1  beat accepted this cycle
- regw_W  out  1  registered write enable
- regmem_W  out  1  registered load flag
- vect_W  out  1  registered vector flag
- regScr_W  out  M  registered destination
- ALUrslt_W  out  V  registered ALU result
- memdata_W  out  V  registered load data

Behaviour:
- Reset (rst=0, asynchronous):
  - All *_W outputs are 0; mem_req is 0.
  - FSM returns to IDLE, beat counter and load buffer are cleared.
  - stall_M is 0 once reset asserts.
  - A reset mid-access abandons the access; no partial write-back occurs.
- Op classification:
  - memop = memw_M | regmem_M.
  - memw_M has priority: if both are 1, the op is a store and regmem_W/regw_W are forced to 0.
- Beat count: BEATS = vect_M ? V/W : 1.
- FSM states:
  - IDLE: memop=1 → ACCESS in the same cycle (mem_req is asserted combinationally); otherwise remain in IDLE.
  - ACCESS: mem_req=1. On mem_req & mem_ready: if beat==BEATS-1 → IDLE, else beat+1.
- Request signals while mem_req=1:
  - mem_we = memw_M.
  - mem_addr = address_M[AW-1:0] + beat (wraps modulo 2^AW).
  - mem_wdata = ALUrslt_M[beat*W +: W].
  - All are held stable until mem_ready.
- Stall rule: stall_M = memop & ~(mem_ready & beat==BEATS-1).
  - This is combinational; ready on the last beat releases the stall in the same cycle.
  - The next instruction is therefore loaded at that edge, with no re-issue of the completed op.
- Load data assembly:
  - Each accepted read beat i writes mem_rdata into ldbuf[i*W +: W].
  - For the last beat, memdata_W is loaded from ldbuf with the current mem_rdata merged into its slot.
  - Scalar load: memdata_W = zero-extended mem_rdata.
- Write-back register update (each rising edge):
  - stall_M=0: all *_W outputs load the M-stage values plus the assembled load data; memdata_W=0 for non-loads.
  - stall_M=1: regw_W and regmem_W load 0 (bubble); other *_W outputs hold.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op with zero-wait memory: BEATS cycles, i.e. BEATS-1 stall cycles.
  - Each cycle with mem_ready=0 adds one stall cycle.
- If mem_ready=1 while mem_req=0, it is ignored.
- ldbuf is cleared when the FSM enters IDLE.

Decomposition:
- Package vproc_mem_pkg:
  - state enum {IDLE, ACCESS}
  - localparam BEATS_V = V/W
  - beat-counter width $clog2(V/W)+1
- Write-back flops reuse the existing generic register module (one instance per field).
- Sub-module mem_beat_seq: FSM, beat counter and load-buffer assembly; the top level holds the classification and write-back registers.

Test Plan:
- Non-memory op: regw_M=1, regScr_M=3, ALUrslt_M=0x5 → next edge regw_W=1, regScr_W=3, ALUrslt_W=0x5, memdata_W=0; stall_M never high.
- Scalar load with mem_ready tied 1: address_M=0x10, rdata=0xDEADBEEF → one mem_req, mem_addr=0x10, no stall; next edge memdata_W=0x...0DEADBEEF, regmem_W=1.
- Vector load, zero-wait: address 0x20, rdata 0x11/0x22/0x33/0x44 per beat → mem_addr 0x20..0x23, stall_M high for 3 cycles; memdata_W=0x00000044_00000033_00000022_00000011; 3 bubbles on regw_W.
- Vector store with mem_ready low for 2 cycles on beat 1: ALUrslt_M=0xA..D words → mem_wdata/mem_addr held during wait; 5 stall cycles total; regw_W=0 throughout.
- Assert rst mid-vector load after beat 2 → mem_req and stall_M drop, all *_W=0; after release, a new scalar load completes normally starting at beat 0.
- memw_M=regmem_M=1 and address 0xFFFFFFFF vector → treated as a store, addresses wrap 0xFFFFFFFF,0x0,0x1,0x2; regmem_W=0.
